// File: rtl/dr_display.sv
// Debug-register display: holds the last 32-bit dr value written by the core
// and scans it as eight hex digits onto a common-anode 7-segment board.
module dr_display #(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dr,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        upd
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [31:0]      shown_q, shown_d;
  logic             upd_q, upd_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       nib;
  logic             blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Capture and scan counters
  always_comb begin
    upd_d   = !freeze && (dr != shown_q);
    shown_d = upd_d ? dr : shown_q;
    div_d   = div_q + 1'b1;
    idx_d   = idx_q;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Display outputs use the pre-edge idx and shown, giving one cycle of latency
  always_comb begin
    nib   = shown_q[{idx_q, 2'b00} +: 4];
    blank = (LZ_BLANK != 0) && (idx_q != 3'd0) &&
            ((shown_q >> {idx_q, 2'b00}) == 32'd0);
    an_d  = ~(8'b1 << idx_q);
    seg_d = blank ? 7'h7F : hex7(nib);
    dp_d  = ~(freeze && (idx_q == 3'd4));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown_q <= '0;
      upd_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      shown_q <= shown_d;
      upd_q   <= upd_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_dr_display.sv
// Directed bench for dr_display with SCAN_DIV=4; a second instance with
// leading-zero blanking disabled shares the same inputs.
module tb_dr_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dr;
  logic        freeze;
  logic [6:0]  seg, seg0;
  logic        dp, dp0;
  logic [7:0]  an, an0;
  logic        upd, upd0;

  int tests = 0;
  int fails = 0;

  dr_display #(.SCAN_DIV(4), .LZ_BLANK(1)) dut (
    .clk(clk), .reset(reset), .dr(dr), .freeze(freeze),
    .seg(seg), .dp(dp), .an(an), .upd(upd)
  );

  dr_display #(.SCAN_DIV(4), .LZ_BLANK(0)) dut0 (
    .clk(clk), .reset(reset), .dr(dr), .freeze(freeze),
    .seg(seg0), .dp(dp0), .an(an0), .upd(upd0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until an shows the wanted digit enable, bounded by one full scan plus slack
  task automatic wait_an(input string tag, input logic [7:0] target);
    for (int i = 0; i < 40; i++) begin
      if (an === target) break;
      step(1);
    end
    chk(tag, {24'd0, an}, {24'd0, target});
  endtask

  logic [6:0] exp_seg2 [8];
  logic [6:0] exp_seg6 [8];
  logic [7:0] exp_an   [8];

  initial begin
    exp_an   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg2 = '{7'h12, 7'h08, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_seg6 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F};

    // 1. reset values and first scan step
    reset  = 1'b0;
    dr     = 32'd0;
    freeze = 1'b0;
    #12;
    chk("rst_an",  {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp",  {31'd0, dp}, 32'd1);
    chk("rst_upd", {31'd0, upd}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    chk("first_an",  {24'd0, an}, 32'hFE);
    chk("first_seg", {25'd0, seg}, 32'h40);
    chk("first_upd", {31'd0, upd}, 32'd0);
    step(3);
    chk("hold_an", {24'd0, an}, 32'hFE);
    step(1);
    chk("step_an", {24'd0, an}, 32'hFD);

    // 2. capture and scan of 0x000012A5
    dr = 32'h0000_12A5;
    step(1);
    chk("cap_upd", {31'd0, upd}, 32'd1);
    step(1);
    chk("cap_upd_off", {31'd0, upd}, 32'd0);
    wait_an("scan2_sync", 8'hFE);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("scan2_an%0d", d),  {24'd0, an},  {24'd0, exp_an[d]});
      chk($sformatf("scan2_seg%0d", d), {25'd0, seg}, {25'd0, exp_seg2[d]});
      step(4);
    end

    // 3. freeze holds the value and lights dp on digit 4
    freeze = 1'b1;
    dr     = 32'hFFFF_FFFF;
    step(1);
    chk("frz_upd", {31'd0, upd}, 32'd0);
    wait_an("frz_sync", 8'hFE);
    chk("frz_seg0", {25'd0, seg}, 32'h12);
    chk("frz_dp0",  {31'd0, dp}, 32'd1);
    wait_an("frz_sync4", 8'hEF);
    chk("frz_dp4",  {31'd0, dp}, 32'd0);
    chk("frz_seg4", {25'd0, seg}, 32'h7F);
    step(4);
    chk("frz_dp5",  {31'd0, dp}, 32'd1);
    freeze = 1'b0;
    step(1);
    chk("unfrz_upd", {31'd0, upd}, 32'd1);
    step(1);
    chk("unfrz_upd_off", {31'd0, upd}, 32'd0);
    wait_an("ff_sync", 8'hFE);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("ff_seg%0d", d), {25'd0, seg}, 32'h0E);
      chk($sformatf("ff_dp%0d", d),  {31'd0, dp}, 32'd1);
      step(4);
    end

    // 4. dr changes every cycle
    for (int i = 0; i < 20; i++) begin
      dr = 32'(i);
      step(1);
      chk($sformatf("inc_upd%0d", i),   {31'd0, upd}, 32'd1);
      chk($sformatf("inc_shown%0d", i), dut.shown_q, 32'(i));
    end
    step(1);
    chk("inc_upd_end", {31'd0, upd}, 32'd0);

    // 5. asynchronous reset mid-scan at idx 5
    wait_an("mid_sync", 8'hDF);
    reset = 1'b0;
    #1;
    chk("mid_an",    {24'd0, an}, 32'hFF);
    chk("mid_seg",   {25'd0, seg}, 32'h7F);
    chk("mid_dp",    {31'd0, dp}, 32'd1);
    chk("mid_shown", dut.shown_q, 32'd0);
    dr = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    step(1);
    chk("rel_an",  {24'd0, an}, 32'hFE);
    chk("rel_seg", {25'd0, seg}, 32'h40);
    chk("rel_upd", {31'd0, upd}, 32'd0);

    // 6. leading-zero handling
    wait_an("lz_sync", 8'hFE);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("nolz_seg%0d", d), {25'd0, seg0}, 32'h40);
      chk($sformatf("lz0_seg%0d", d),  {25'd0, seg}, (d == 0) ? 32'h40 : 32'h7F);
      step(4);
    end
    dr = 32'h0001_0000;
    step(1);
    chk("lz_upd", {31'd0, upd}, 32'd1);
    step(1);
    wait_an("lz1_sync", 8'hFE);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("lz1_seg%0d", d), {25'd0, seg}, {25'd0, exp_seg6[d]});
      step(4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
